orient_scan_ctrl: RTL

//  Sequences reads of the square binary frame buffer in one of four orientation orders (0/90/180/270 deg).

---
 rtl/orient_scan_ctrl_pkg.sv | 8 +
 rtl/orient_scan_ctrl_if.sv | 27 ++
 rtl/orient_scan_ctrl_addr_gen.sv | 58 +++++
 rtl/orient_scan_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/orient_scan_ctrl_pkg.sv
// Shared types for the orientation scan controller.
// Optional feature macro used by the top: SCAN_LINE_CNT_EN.
package orient_scan_pkg;
  localparam int DIM_LOG2_DEF = 5;

  typedef enum logic [1:0] {OR_0, OR_90, OR_180, OR_270} orient_e;
  typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_DRAIN, SCAN_DONE} scan_state_e;
endpackage

// File: rtl/orient_scan_ctrl_if.sv
// Control, frame-buffer read and pixel-stream signals of orient_scan_ctrl.
interface orient_scan_ctrl_if #(parameter int DIM_LOG2 = 5, parameter int DATA_W = 1);
  import orient_scan_pkg::*;

  logic                  start;
  orient_e               orient;
  logic                  clear;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [2*DIM_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_W-1:0]     pix_data;
  logic                  pix_last;
  logic [2*DIM_LOG2:0]   line_cnt;

  modport master (
    input  start, orient, clear, rd_data, pix_ready,
    output busy, done, rd_en, rd_addr, pix_valid, pix_data, pix_last, line_cnt
  );
  modport slave (
    output start, orient, clear, rd_data, pix_ready,
    input  busy, done, rd_en, rd_addr, pix_valid, pix_data, pix_last, line_cnt
  );
endinterface

// File: rtl/orient_scan_ctrl_addr_gen.sv
// Row/col walk for one scan; outer counter steps when inner wraps, mapped to {row,col} by orientation.
module scan_addr_gen import orient_scan_pkg::*; #(
  parameter int DIM_LOG2 = DIM_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_i,
  input  logic                  step_i,
  input  orient_e               orient_i,
  output logic [2*DIM_LOG2-1:0] addr_o,
  output logic                  last_o
);
  typedef logic [DIM_LOG2-1:0] idx_t;

  idx_t    outer_q, outer_d, inner_q, inner_d, row, col;
  orient_e orient_q, orient_d;

  always_comb begin
    outer_d  = outer_q;
    inner_d  = inner_q;
    orient_d = orient_q;
    if (init_i) begin
      outer_d  = '0;
      inner_d  = '0;
      orient_d = orient_i;
    end else if (step_i) begin
      inner_d = inner_q + 1'b1;
      if (&inner_q) outer_d = outer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outer_q  <= '0;
      inner_q  <= '0;
      orient_q <= OR_0;
    end else begin
      outer_q  <= outer_d;
      inner_q  <= inner_d;
      orient_q <= orient_d;
    end
  end

  // N-1-x is the bitwise inverse for a power-of-two side
  always_comb begin
    row = outer_q;
    col = inner_q;
    unique case (orient_q)
      OR_0:   begin row = outer_q;  col = inner_q;  end
      OR_90:  begin col = outer_q;  row = ~inner_q; end
      OR_180: begin row = ~outer_q; col = ~inner_q; end
      OR_270: begin col = ~outer_q; row = inner_q;  end
    endcase
  end

  assign addr_o = {row, col};
  assign last_o = (&outer_q) & (&inner_q);
endmodule

// File: rtl/orient_scan_ctrl.sv
// Frame-buffer scan sequencer: FSM, read credit, 2-entry pixel FIFO, optional line counter.
// Optional feature macro: SCAN_LINE_CNT_EN (accepted non-zero pixel count on line_cnt).
module orient_scan_ctrl import orient_scan_pkg::*; #(
  parameter int DIM_LOG2 = DIM_LOG2_DEF,
  parameter int DATA_W   = 1
) (
  input logic                clk,
  input logic                reset,
  orient_scan_ctrl_if.master bus
);
  localparam int AW = 2*DIM_LOG2;
  localparam int CW = AW + 1;
  localparam logic [1:0] ST_IDLE  = SCAN_IDLE;
  localparam logic [1:0] ST_SCAN  = SCAN_RUN;
  localparam logic [1:0] ST_DRAIN = SCAN_DRAIN;
  localparam logic [1:0] ST_DONE  = SCAN_DONE;

  logic [1:0]             state_q, state_d;
  logic [1:0]             occ_q, occ_d;
  logic                   infl_q, infl_last_q;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0][DATA_W:0]   fifo_q;
  logic                   start_acc, issue, pop, gen_last;
  logic [AW-1:0]          gen_addr;

  assign start_acc = (state_q == ST_IDLE) && bus.start && !bus.clear;
  assign pop       = bus.pix_valid && bus.pix_ready;
  // occupancy after this cycle's capture and pop; the credit check uses it so a
  // departing head frees its slot immediately and the stream runs at 1 pixel/cycle
  assign occ_d     = occ_q + {1'b0, infl_q} - {1'b0, pop};
  assign issue     = (state_q == ST_SCAN) && (occ_d < 2'd2) && !bus.clear;

  scan_addr_gen #(.DIM_LOG2(DIM_LOG2)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .init_i   (start_acc),
    .step_i   (issue),
    .orient_i (bus.orient),
    .addr_o   (gen_addr),
    .last_o   (gen_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_acc)         state_d = ST_SCAN;
      ST_SCAN:  if (issue && gen_last) state_d = ST_DRAIN;
      ST_DRAIN: if (occ_d == 2'd0)     state_d = ST_DONE;
      default:                         state_d = ST_IDLE;
    endcase
    if (bus.clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      occ_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_q      <= '0;
    end else begin
      state_q     <= state_d;
      infl_q      <= issue;
      infl_last_q <= issue && gen_last;
      if (bus.clear) begin
        occ_q    <= '0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        occ_q <= occ_d;
        if (infl_q) begin
          fifo_q[wr_ptr_q] <= {infl_last_q, bus.rd_data};
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = gen_addr;
  assign bus.pix_valid = (occ_q != 2'd0);
  assign {bus.pix_last, bus.pix_data} = bus.pix_valid ? fifo_q[rd_ptr_q] : '0;

`ifdef SCAN_LINE_CNT_EN
  localparam logic [CW-1:0] CNT_MAX = {1'b1, {AW{1'b0}}};
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_acc)
      cnt_d = '0;
    else if (pop && (|bus.pix_data) && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.line_cnt = cnt_q;
`else
  assign bus.line_cnt = '0;
`endif
endmodule
